// File: rtl/ahb_slave_mem.sv
// ----------------------------------------------------------------------------
// ahb_slave_mem
//
// Synchronous-SRAM AHB slave responder for one 4 KB slave region. Only the
// in-region offset (address bits [11:0]) is used; higher bits are the
// decoder's concern. Each OKAY NONSEQ/SEQ transfer gets WAIT_STATES ready-low
// cycles before its completing cycle. Misaligned or oversized transfers get
// the two-cycle ERROR response and never touch memory.
//
// Valid/ready handshake: an address phase is taken on a rising edge when
// slave_sel_in & bus_ready_in & bus_trans_in[1]. Its data phase ends on the
// first edge at which slave_ready_out is 1. Write data is sampled and
// written on that edge; read data is presented on slave_rdata_out during
// that completing cycle and holds its value afterwards.
//
// Optional feature (macro AHB_SLAVE_RO_REGION_EN): adds parameter RO_WORDS.
// Writes to word indices below RO_WORDS get the ERROR response and leave
// memory unchanged; reads there are OKAY. Without the macro every word is
// writable.
//
// Ports:
//   bus_clk_in       bus clock (HCLK)
//   bus_rstn_in      asynchronous active-low reset (HRESETn)
//   slave_sel_in     HSEL from the address decoder
//   bus_addr_in      HADDR
//   bus_trans_in     HTRANS (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
//   bus_write_in     HWRITE
//   bus_size_in      HSIZE (0 byte, 1 half, 2 word)
//   bus_wdata_in     HWDATA, valid in the data phase
//   bus_ready_in     global HREADY
//   slave_rdata_out  HRDATA
//   slave_ready_out  HREADYOUT
//   slave_resp_out   HRESP (0 OKAY, 1 ERROR)
// ----------------------------------------------------------------------------
module ahb_slave_mem #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 1024,
    parameter int WAIT_STATES    = 1
`ifdef AHB_SLAVE_RO_REGION_EN
    ,
    parameter int RO_WORDS       = 64
`endif
) (
    input  logic                      bus_clk_in,
    input  logic                      bus_rstn_in,
    input  logic                      slave_sel_in,
    input  logic [AHB_ADDR_WIDTH-1:0] bus_addr_in,
    input  logic [1:0]                bus_trans_in,
    input  logic                      bus_write_in,
    input  logic [2:0]                bus_size_in,
    input  logic [AHB_DATA_WIDTH-1:0] bus_wdata_in,
    input  logic                      bus_ready_in,
    output logic [AHB_DATA_WIDTH-1:0] slave_rdata_out,
    output logic                      slave_ready_out,
    output logic                      slave_resp_out
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int LANES = AHB_DATA_WIDTH / 8;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t                    state;
    logic [3:0]                wait_cnt;
    logic                      ready_q;
    logic                      resp_q;
    logic [AHB_DATA_WIDTH-1:0] rdata_q;

    // Registered address phase of the transfer currently in its data phase.
    logic [11:0]               dp_addr;
    logic                      dp_write;
    logic [2:0]                dp_size;
    logic                      dp_active;

    logic [AHB_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    logic [11:0]      ap_off;
    logic [IDX_W-1:0] ap_idx;
    logic             accept;
    logic             align_err;
    logic             ro_err;
    logic             ap_err;

    assign ap_off = bus_addr_in[11:0];
    assign ap_idx = ap_off[IDX_W+1:2];

    // New address phases are only taken while this slave drives ready high,
    // i.e. when idle/completing or in the second ERROR cycle.
    assign accept = slave_sel_in & bus_ready_in & bus_trans_in[1] &
                    ((state == ST_IDLE) | (state == ST_ERR2));

    always_comb begin
        align_err = 1'b0;
        case (bus_size_in)
            3'd0:    align_err = 1'b0;
            3'd1:    align_err = ap_off[0];
            3'd2:    align_err = (ap_off[1:0] != 2'b00);
            default: align_err = 1'b1;
        endcase
    end

`ifdef AHB_SLAVE_RO_REGION_EN
    assign ro_err = bus_write_in & (int'(ap_idx) < RO_WORDS);
`else
    assign ro_err = 1'b0;
`endif

    assign ap_err = align_err | ro_err;

    // ------------------------------------------------------------------
    // Data-phase decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] dp_idx;
    logic [LANES-1:0] byte_en;
    logic             complete;
    logic             do_write;

    assign dp_idx = dp_addr[IDX_W+1:2];

    // Little-endian lane selection. Error transfers never complete, so the
    // default arm only ever serves word transfers.
    always_comb begin
        byte_en = '0;
        case (dp_size)
            3'd0:    byte_en = 4'b0001 << dp_addr[1:0];
            3'd1:    byte_en = dp_addr[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // The completing cycle is the IDLE state with a live data phase.
    assign complete = (state == ST_IDLE) & dp_active;
    assign do_write = complete & dp_write;

    // ------------------------------------------------------------------
    // Read path. With WAIT_STATES=0 the read word is loaded on the
    // acceptance edge from the incoming index; otherwise on the last wait
    // edge from the registered index. A write completing on the same edge
    // to the same word is merged in lane by lane (write-first).
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]          rd_idx;
    logic                      rd_fwd;
    logic [AHB_DATA_WIDTH-1:0] mem_rd;
    logic [AHB_DATA_WIDTH-1:0] rd_word;

    assign rd_idx = (state == ST_WAIT) ? dp_idx : ap_idx;
    assign rd_fwd = do_write & (dp_idx == rd_idx);
    assign mem_rd = mem[rd_idx];

    always_comb begin
        rd_word = mem_rd;
        for (int i = 0; i < LANES; i++) begin
            if (rd_fwd && byte_en[i]) begin
                rd_word[8*i +: 8] = bus_wdata_in[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory array (contents are not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge bus_clk_in) begin
        if (do_write) begin
            for (int i = 0; i < LANES; i++) begin
                if (byte_en[i]) begin
                    mem[dp_idx][8*i +: 8] <= bus_wdata_in[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FSM with registered ready/resp/rdata
    // ------------------------------------------------------------------
    always_ff @(posedge bus_clk_in or negedge bus_rstn_in) begin
        if (!bus_rstn_in) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            ready_q   <= 1'b1;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
            dp_addr   <= 12'd0;
            dp_write  <= 1'b0;
            dp_size   <= 3'd0;
            dp_active <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    if (accept) begin
                        dp_addr  <= ap_off;
                        dp_write <= bus_write_in;
                        dp_size  <= bus_size_in;
                        if (ap_err) begin
                            state     <= ST_ERR1;
                            ready_q   <= 1'b0;
                            resp_q    <= 1'b1;
                            dp_active <= 1'b0;
                        end else if (WAIT_STATES > 0) begin
                            state     <= ST_WAIT;
                            ready_q   <= 1'b0;
                            resp_q    <= 1'b0;
                            wait_cnt  <= WAIT_INIT;
                            dp_active <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            ready_q   <= 1'b1;
                            resp_q    <= 1'b0;
                            dp_active <= 1'b1;
                            if (!bus_write_in) begin
                                rdata_q <= rd_word;
                            end
                        end
                    end else begin
                        state     <= ST_IDLE;
                        ready_q   <= 1'b1;
                        resp_q    <= 1'b0;
                        dp_active <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                        if (!dp_write) begin
                            rdata_q <= rd_word;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state   <= ST_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b0;
                end
            endcase
        end
    end

    assign slave_ready_out = ready_q;
    assign slave_resp_out  = resp_q;
    assign slave_rdata_out = rdata_q;

    // Region decode and HTRANS[0] are intentionally not used here.
    logic unused_bits;
    assign unused_bits = ^{bus_addr_in[AHB_ADDR_WIDTH-1:12], bus_trans_in[0]};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_mem
//
// Three instances of ahb_slave_mem with WAIT_STATES = 0, 1 and 3 share the
// address/control/write-data lines; each has its own select, and each one's
// global HREADY is its own HREADYOUT (single-slave bus). Directed vectors
// with hand-computed expectations, plus hand-written pipelined sequences.
// ----------------------------------------------------------------------------
module tb_ahb_slave_mem;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  sel;
    logic [31:0] b_addr;
    logic [1:0]  b_trans;
    logic        b_write;
    logic [2:0]  b_size;
    logic [31:0] b_wdata;

    wire         rdy0, rdy1, rdy2;
    wire         rsp0, rsp1, rsp2;
    wire  [31:0] rd0, rd1, rd2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ahb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
        .bus_clk_in(clk), .bus_rstn_in(rstn), .slave_sel_in(sel[0]),
        .bus_addr_in(b_addr), .bus_trans_in(b_trans), .bus_write_in(b_write),
        .bus_size_in(b_size), .bus_wdata_in(b_wdata), .bus_ready_in(rdy0),
        .slave_rdata_out(rd0), .slave_ready_out(rdy0), .slave_resp_out(rsp0)
    );

    ahb_slave_mem #(.WAIT_STATES(1)) u_ws1 (
        .bus_clk_in(clk), .bus_rstn_in(rstn), .slave_sel_in(sel[1]),
        .bus_addr_in(b_addr), .bus_trans_in(b_trans), .bus_write_in(b_write),
        .bus_size_in(b_size), .bus_wdata_in(b_wdata), .bus_ready_in(rdy1),
        .slave_rdata_out(rd1), .slave_ready_out(rdy1), .slave_resp_out(rsp1)
    );

    ahb_slave_mem #(.WAIT_STATES(3)) u_ws3 (
        .bus_clk_in(clk), .bus_rstn_in(rstn), .slave_sel_in(sel[2]),
        .bus_addr_in(b_addr), .bus_trans_in(b_trans), .bus_write_in(b_write),
        .bus_size_in(b_size), .bus_wdata_in(b_wdata), .bus_ready_in(rdy2),
        .slave_rdata_out(rd2), .slave_ready_out(rdy2), .slave_resp_out(rsp2)
    );

    function automatic logic get_rdy(int i);
        case (i)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic get_rsp(int i);
        case (i)
            0:       return rsp0;
            1:       return rsp1;
            default: return rsp2;
        endcase
    endfunction

    function automatic logic [31:0] get_rd(int i);
        case (i)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive after the edge; outputs are sampled here too (1 time unit after).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input int inst, input logic wr, input logic [31:0] a,
                              input logic [2:0] sz);
        sel          = 3'b000;
        sel[inst]    = 1'b1;
        b_addr       = a;
        b_trans      = 2'd2;
        b_write      = wr;
        b_size       = sz;
    endtask

    // One non-pipelined transfer: address phase, bounded wait loop, checks.
    task automatic do_xfer(input int inst, input logic wr, input logic [31:0] a,
                           input logic [2:0] sz, input logic [31:0] wd,
                           input logic exp_err, input logic [31:0] exp_rd,
                           input int exp_waits, input string tag);
        int n;
        addr_phase(inst, wr, a, sz);
        tick();
        b_trans = 2'd0;
        b_wdata = wd;
        n = 0;
        while (get_rdy(inst) == 1'b0 && n < 40) begin
            check({tag, " resp during wait"}, 32'(get_rsp(inst)), 32'(exp_err));
            tick();
            n++;
        end
        check({tag, " wait cycles"}, 32'(n), 32'(exp_waits));
        check({tag, " final resp"}, 32'(get_rsp(inst)), 32'(exp_err));
        if (!wr && !exp_err) begin
            check({tag, " rdata"}, get_rd(inst), exp_rd);
        end
        tick();
        sel = 3'b000;
    endtask

    typedef struct {
        int          inst;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          waits;
    } vec_t;

    vec_t vecs [20];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1, 1'b1, 32'h4568_0010, 3'd2, 32'hDEAD_BEEF, 1'b0, 32'h0,         1};
        vecs[1]  = '{1, 1'b0, 32'h4568_0010, 3'd2, 32'h0,         1'b0, 32'hDEAD_BEEF, 1};
        vecs[2]  = '{1, 1'b1, 32'h4568_0020, 3'd2, 32'h1122_3344, 1'b0, 32'h0,         1};
        vecs[3]  = '{1, 1'b1, 32'h4568_0022, 3'd0, 32'h99AA_7766, 1'b0, 32'h0,         1};
        vecs[4]  = '{1, 1'b0, 32'h4568_0020, 3'd2, 32'h0,         1'b0, 32'h11AA_3344, 1};
        vecs[5]  = '{1, 1'b1, 32'h0000_0020, 3'd1, 32'h5555_BEEF, 1'b0, 32'h0,         1};
        vecs[6]  = '{1, 1'b0, 32'h0000_0020, 3'd2, 32'h0,         1'b0, 32'h11AA_BEEF, 1};
        vecs[7]  = '{1, 1'b1, 32'h0000_0022, 3'd2, 32'hFFFF_FFFF, 1'b1, 32'h0,         1};
        vecs[8]  = '{1, 1'b1, 32'h0000_0021, 3'd1, 32'hFFFF_FFFF, 1'b1, 32'h0,         1};
        vecs[9]  = '{1, 1'b1, 32'h0000_0020, 3'd3, 32'hFFFF_FFFF, 1'b1, 32'h0,         1};
        vecs[10] = '{1, 1'b0, 32'h0000_0020, 3'd2, 32'h0,         1'b0, 32'h11AA_BEEF, 1};
        vecs[11] = '{1, 1'b1, 32'h0000_0023, 3'd0, 32'h4400_0000, 1'b0, 32'h0,         1};
        vecs[12] = '{1, 1'b0, 32'h0000_0020, 3'd2, 32'h0,         1'b0, 32'h44AA_BEEF, 1};
        vecs[13] = '{1, 1'b0, 32'hFFFF_F010, 3'd2, 32'h0,         1'b0, 32'hDEAD_BEEF, 1};
        vecs[14] = '{0, 1'b1, 32'h0000_0100, 3'd2, 32'hCAFE_F00D, 1'b0, 32'h0,         0};
        vecs[15] = '{0, 1'b0, 32'h0000_0100, 3'd2, 32'h0,         1'b0, 32'hCAFE_F00D, 0};
        vecs[16] = '{0, 1'b1, 32'h0000_0102, 3'd1, 32'h1234_0000, 1'b0, 32'h0,         0};
        vecs[17] = '{0, 1'b0, 32'h0000_0100, 3'd2, 32'h0,         1'b0, 32'h1234_F00D, 0};
        vecs[18] = '{2, 1'b1, 32'h0000_0044, 3'd2, 32'h1234_5678, 1'b0, 32'h0,         3};
        vecs[19] = '{2, 1'b0, 32'h0000_0044, 3'd2, 32'h0,         1'b0, 32'h1234_5678, 3};

        // Clock/reset
        rstn    = 1'b0;
        sel     = 3'b000;
        b_addr  = 32'h0;
        b_trans = 2'd0;
        b_write = 1'b0;
        b_size  = 3'd0;
        b_wdata = 32'h0;
        tick();
        tick();
        check("reset ready ws0", 32'(rdy0), 32'd1);
        check("reset ready ws1", 32'(rdy1), 32'd1);
        check("reset resp ws1",  32'(rsp1), 32'd0);
        check("reset rdata ws1", rd1, 32'h0);
        check("reset rdata ws3", rd2, 32'h0);
        rstn = 1'b1;
        tick();

        // Table-driven single transfers
        for (int i = 0; i < 20; i++) begin
            do_xfer(vecs[i].inst, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                    vecs[i].err, vecs[i].rdata, vecs[i].waits, $sformatf("vec%0d", i));
        end

        // Misaligned read, then a NONSEQ presented in the ERR2 cycle
        addr_phase(1, 1'b0, 32'h4568_0003, 3'd2);
        tick();
        b_trans = 2'd0;
        check("err1 ready", 32'(rdy1), 32'd0);
        check("err1 resp",  32'(rsp1), 32'd1);
        tick();
        check("err2 ready", 32'(rdy1), 32'd1);
        check("err2 resp",  32'(rsp1), 32'd1);
        addr_phase(1, 1'b0, 32'h0000_0020, 3'd2);
        tick();
        b_trans = 2'd0;
        check("after-err wait ready", 32'(rdy1), 32'd0);
        check("after-err wait resp",  32'(rsp1), 32'd0);
        tick();
        check("after-err done ready", 32'(rdy1), 32'd1);
        check("after-err done resp",  32'(rsp1), 32'd0);
        check("after-err rdata",      rd1, 32'h44AA_BEEF);
        tick();
        sel = 3'b000;

        // IDLE and BUSY while selected, NONSEQ while not selected
        sel     = 3'b010;
        b_addr  = 32'h0000_0020;
        b_write = 1'b1;
        b_size  = 3'd2;
        b_wdata = 32'hFFFF_FFFF;
        b_trans = 2'd0;
        tick();
        check("idle sel ready", 32'(rdy1), 32'd1);
        check("idle sel resp",  32'(rsp1), 32'd0);
        b_trans = 2'd1;
        tick();
        check("busy sel ready", 32'(rdy1), 32'd1);
        check("busy sel resp",  32'(rsp1), 32'd0);
        sel     = 3'b000;
        b_trans = 2'd2;
        tick();
        check("unsel ready", 32'(rdy1), 32'd1);
        check("unsel resp",  32'(rsp1), 32'd0);
        b_trans = 2'd0;
        tick();
        check("rdata hold", rd1, 32'h44AA_BEEF);
        do_xfer(1, 1'b0, 32'h0000_0020, 3'd2, 32'h0, 1'b0, 32'h44AA_BEEF, 1, "no-access read");

        // WAIT_STATES=0: write then read of the same word back to back
        addr_phase(0, 1'b1, 32'h0000_0040, 3'd2);
        tick();
        check("b2b write ready", 32'(rdy0), 32'd1);
        check("b2b write resp",  32'(rsp0), 32'd0);
        b_wdata = 32'h0000_0005;
        addr_phase(0, 1'b0, 32'h0000_0040, 3'd2);
        tick();
        b_trans = 2'd0;
        check("b2b read ready", 32'(rdy0), 32'd1);
        check("b2b read resp",  32'(rsp0), 32'd0);
        check("b2b read rdata", rd0, 32'h0000_0005);
        tick();
        sel = 3'b000;

        // Byte write forwarded into an immediately following read
        do_xfer(0, 1'b1, 32'h0000_0044, 3'd2, 32'hA1B2_C3D4, 1'b0, 32'h0, 0, "pre 0x44");
        addr_phase(0, 1'b1, 32'h0000_0044, 3'd0);
        tick();
        b_wdata = 32'h0000_0077;
        addr_phase(0, 1'b0, 32'h0000_0044, 3'd2);
        tick();
        b_trans = 2'd0;
        check("fwd byte rdata", rd0, 32'hA1B2_C377);
        tick();
        sel = 3'b000;
        do_xfer(0, 1'b0, 32'h0000_0040, 3'd2, 32'h0, 1'b0, 32'h0000_0005, 0, "reread 0x40");

        // Reset during the second wait cycle of a WAIT_STATES=3 write
        addr_phase(2, 1'b1, 32'h0000_0044, 3'd2);
        tick();
        b_trans = 2'd0;
        b_wdata = 32'hFFFF_0000;
        check("ws3 wait1 ready", 32'(rdy2), 32'd0);
        tick();
        check("ws3 wait2 ready", 32'(rdy2), 32'd0);
        rstn = 1'b0;
        #1;
        check("mid reset ready", 32'(rdy2), 32'd1);
        check("mid reset resp",  32'(rsp2), 32'd0);
        check("mid reset rdata", rd2, 32'h0);
        tick();
        rstn = 1'b1;
        sel  = 3'b000;
        tick();
        do_xfer(2, 1'b0, 32'h0000_0044, 3'd2, 32'h0, 1'b0, 32'h1234_5678, 3, "post-reset read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- Synchronous-SRAM AHB slave responder that answers transfers routed to it by the address decoder via `slave_sel_in` (HSEL).
- Implements the AHB data-phase handshake: HREADYOUT, a fixed configurable number of wait states, and a two-cycle ERROR response.
- One instance per 4 KB slave region; only the low 12 address bits (the in-region offset) are used.
- Its ready/resp/rdata outputs feed the bus multiplexer.

Parameters:
- AHB_ADDR_WIDTH, 32, address bus width.
- AHB_DATA_WIDTH, 32, data bus width; fixed at 32 (4 byte lanes).
- MEM_DEPTH, 1024, number of 32-bit words (covers 4 KB offset, addr[11:2]).
- WAIT_STATES, 1, ready-low cycles inserted per OKAY NONSEQ/SEQ data phase; legal range 0..15.

Ports:
- bus_clk_in  input  1  bus clock (HCLK)
- bus_rstn_in  input  1  reset, asynchronous, active-low (HRESETn)
- slave_sel_in  input  1  HSEL from decoder
- bus_addr_in  input  AHB_ADDR_WIDTH  HADDR
- bus_trans_in  input  2  HTRANS: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- bus_write_in  input  1  HWRITE
- bus_size_in  input  3  HSIZE: 0 byte, 1 half, 2 word
- bus_wdata_in  input  32  HWDATA, valid in the data phase
- bus_ready_in  input  1  global HREADY (bus-level ready)
- slave_rdata_out  output  32  HRDATA
- slave_ready_out  output  1  HREADYOUT
- slave_resp_out  output  1  HRESP: 0 OKAY, 1 ERROR

Behaviour:
- Reset and clocking:
  - Reset bus_rstn_in, asynchronous, active-low; clock bus_clk_in.
  - On reset: slave_ready_out=1, slave_resp_out=0, slave_rdata_out=0, FSM=IDLE, wait counter=0.
  - Memory contents are not reset.
- Address-phase capture:
  - A transfer is accepted on a rising edge when slave_sel_in & bus_ready_in & bus_trans_in[1].
  - On acceptance, register addr[11:0], write, size and an error flag.
- Error flag conditions:
  - size > 2;
  - size==1 with addr[0]!=0;
  - size==2 with addr[1:0]!=0.
- Zero-wait responses:
  - IDLE/BUSY transfers while selected: OKAY with zero wait.
  - Non-selected cycles: ready_out=1, resp=0.
- FSM states IDLE, WAIT, ERR1, ERR2:
  - IDLE: if an accepted transfer has the error flag set -> ERR1. Else if WAIT_STATES>0 -> WAIT with counter=WAIT_STATES-1. Else complete the transfer in the next cycle (ready=1).
  - WAIT: ready_out=0, resp=0. Counter decrements each cycle; when it reaches 0 the next cycle is the completing cycle (ready=1) and the FSM returns to IDLE.
  - ERR1: ready_out=0, resp=1.
  - ERR2: ready_out=1, resp=1. A pipelined address phase sampled in ERR2 is accepted normally.
- Write handling:
  - Write data is taken from bus_wdata_in in the completing data cycle (ready_out=1) and written that edge.
  - Byte lanes are little-endian per size/addr[1:0]: byte lane=addr[1:0]; half lanes {addr[1],0}+1..0; word all lanes.
  - No write occurs on an ERROR response.
- Read handling:
  - Memory is read with the registered word index.
  - slave_rdata_out holds the full 32-bit word in the completing cycle.
  - slave_rdata_out holds its last value otherwise (no zeroing).
- Pipelining:
  - With WAIT_STATES=0, back-to-back NONSEQ/SEQ transfers complete one per cycle.
  - A read immediately after a write to the same word returns the new data (write-first forwarding).
- Reset asserted mid-WAIT or mid-ERR: immediate return to reset values; the pending write is discarded.
- Address bits above 11 are ignored (decode is the decoder's job).

Optional Feature:
- Macro: AHB_SLAVE_RO_REGION_EN
- When defined:
  - Adds parameter RO_WORDS (default 64).
  - Writes whose word index < RO_WORDS set the error flag and receive the two-cycle ERROR response; memory is unchanged.
  - Reads of that region are OKAY.
- When undefined: all words are writable and the parameter is absent.

Test Plan:
- WAIT_STATES=1:
  - Write word 0xDEADBEEF to 0x45680010, then read 0x45680010 -> one ready-low cycle on each transfer, resp=0, rdata=0xDEADBEEF.
- Byte lanes:
  - Preload 0x11223344 at offset 0x20, byte-write 0xAA to 0x45680022 -> read gives 0x11AA3344.
  - Half-write 0xBEEF to 0x20 -> read gives 0x11AABEEF.
- Misaligned:
  - Word read at 0x45680003 -> ready=0/resp=1, then ready=1/resp=1; no memory change.
  - Following NONSEQ completes OKAY.
- WAIT_STATES=0, back-to-back:
  - Write 0x5 to 0x40, then read 0x40 in the next address phase -> read returns 0x5, no ready-low cycles.
- IDLE/unselected:
  - trans=IDLE with sel=1, and trans=NONSEQ with sel=0 -> ready=1, resp=0, no memory access.
- Reset mid-transfer:
  - WAIT_STATES=3, assert bus_rstn_in low during the second wait cycle of a write to 0x44 -> outputs ready=1/resp=0/rdata=0 immediately.
  - After release, read 0x44 returns the pre-write value.
